// File: rtl/seg_display_ctrl_if.sv
// Bus between status/result logic and the 7-segment display controller.
// Ports: number/dp/load/lz_en/brightness/blink_mask in; pending/digit/segment out.
interface seg_display_ctrl_if #(
    parameter int NUM_DIGITS  = 8,
    parameter int BRIGHT_BITS = 4
) ();
    logic [4*NUM_DIGITS-1:0] number;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    load;
    logic                    lz_en;
    logic [BRIGHT_BITS-1:0]  brightness;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    pending;
    logic [NUM_DIGITS-1:0]   digit;
    logic [7:0]              segment;

    modport master (
        output number, dp, load, lz_en, brightness, blink_mask,
        input  pending, digit, segment
    );

    modport slave (
        input  number, dp, load, lz_en, brightness, blink_mask,
        output pending, digit, segment
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// Time-multiplexed 7-segment controller: frame-synchronous load, LZ blanking, PWM, blink.
// Ports: clk_i, rst_i (sync, active-high), bus_if (slave side of seg_display_ctrl_if).
module seg_display_ctrl #(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_INTERVAL = 10_000,
    parameter int BRIGHT_BITS   = 4,
    parameter int BLINK_FRAMES  = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    seg_display_ctrl_if.slave bus_if
);
    // cnt shares the width of on_cycles, which may equal SCAN_INTERVAL
    localparam int CW = $clog2(SCAN_INTERVAL + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int NW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_INTERVAL - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] f;
        case (n)
            4'h0:    f = 7'b0111111;
            4'h1:    f = 7'b0000110;
            4'h2:    f = 7'b1011011;
            4'h3:    f = 7'b1001111;
            4'h4:    f = 7'b1100110;
            4'h5:    f = 7'b1101101;
            4'h6:    f = 7'b1111101;
            4'h7:    f = 7'b0000111;
            4'h8:    f = 7'b1111111;
            4'h9:    f = 7'b1101111;
            4'hA:    f = 7'b1110111;
            4'hB:    f = 7'b1111100;
            4'hC:    f = 7'b0111001;
            4'hD:    f = 7'b1011110;
            4'hE:    f = 7'b1111001;
            default: f = 7'b1110001;
        endcase
        return f;
    endfunction

    logic [NW-1:0]         stg_num_q, stg_num_d;
    logic [NUM_DIGITS-1:0] stg_dp_q,  stg_dp_d;
    logic                  pend_q,    pend_d;
    logic [NW-1:0]         shd_num_q, shd_num_d;
    logic [NUM_DIGITS-1:0] shd_dp_q,  shd_dp_d;
    logic [NUM_DIGITS-1:0] lz_q,      lz_d;
    logic [CW-1:0]         cnt_q,     cnt_d;
    logic [IW-1:0]         idx_q,     idx_d;
    logic [FW-1:0]         fcnt_q,    fcnt_d;
    logic                  bph_q,     bph_d;
    logic [CW-1:0]         on_q,      on_d;
    logic [NUM_DIGITS-1:0] digit_q,   digit_d;
    logic [7:0]            seg_q,     seg_d;

    logic                  slot_end;
    logic                  frame_end;
    logic [31:0]           on_prod;
    logic [CW-1:0]         on_now;
    logic [NW-1:0]         src_num;
    logic [NUM_DIGITS-1:0] src_dp;
    logic [NUM_DIGITS-1:0] lz_calc;
    logic                  lz_run;
    logic                  lit;
    logic [3:0]            nib;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    // Full-width product so the maximum code yields exactly SCAN_INTERVAL.
    assign on_prod = (32'(bus_if.brightness) + 32'd1)
                   * 32'(SCAN_INTERVAL);

    // Brightness is taken live at cnt==0 so the first slot cycle uses it.
    assign on_now = (cnt_q == '0) ? CW'(on_prod >> BRIGHT_BITS) : on_q;

    // Mask follows whatever the shadow will hold for the coming frame.
    assign src_num = pend_q ? stg_num_q : shd_num_q;
    assign src_dp  = pend_q ? stg_dp_q  : shd_dp_q;

    always_comb begin
        lz_calc = '0;
        lz_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lz_run && src_num[4*i +: 4] == 4'd0 && !src_dp[i]) begin
                lz_calc[i] = 1'b1;
            end else begin
                lz_run = 1'b0;
            end
        end
        if (!bus_if.lz_en) begin
            lz_calc = '0;
        end
    end

    assign nib = shd_num_q[{idx_q, 2'b00} +: 4];

    assign lit = (cnt_q < on_now)
              && !lz_q[idx_q]
              && !(!bph_q && bus_if.blink_mask[idx_q]);

    always_comb begin
        stg_num_d = stg_num_q;
        stg_dp_d  = stg_dp_q;
        pend_d    = pend_q;
        shd_num_d = shd_num_q;
        shd_dp_d  = shd_dp_q;
        lz_d      = lz_q;
        fcnt_d    = fcnt_q;
        bph_d     = bph_q;
        on_d      = on_now;
        cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
        idx_d     = idx_q;

        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        if (frame_end) begin
            lz_d = lz_calc;
            if (pend_q) begin
                shd_num_d = stg_num_q;
                shd_dp_d  = stg_dp_q;
                pend_d    = 1'b0;
            end
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d = '0;
                bph_d  = ~bph_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        // A load on the boundary cycle is staged for the next frame.
        if (bus_if.load) begin
            stg_num_d = bus_if.number;
            stg_dp_d  = bus_if.dp;
            pend_d    = 1'b1;
        end
    end

    always_comb begin
        digit_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_d[i] = lit && (idx_q == IW'(i));
        end
        seg_d = lit ? {shd_dp_q[idx_q], font(nib)} : 8'h00;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stg_num_q <= '0;
            stg_dp_q  <= '0;
            pend_q    <= 1'b0;
            shd_num_q <= '0;
            shd_dp_q  <= '0;
            lz_q      <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            fcnt_q    <= '0;
            bph_q     <= 1'b1;
            on_q      <= '0;
            digit_q   <= '0;
            seg_q     <= '0;
        end else begin
            stg_num_q <= stg_num_d;
            stg_dp_q  <= stg_dp_d;
            pend_q    <= pend_d;
            shd_num_q <= shd_num_d;
            shd_dp_q  <= shd_dp_d;
            lz_q      <= lz_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            fcnt_q    <= fcnt_d;
            bph_q     <= bph_d;
            on_q      <= on_d;
            digit_q   <= digit_d;
            seg_q     <= seg_d;
        end
    end

    assign bus_if.pending = pend_q;
    assign bus_if.digit   = digit_q;
    assign bus_if.segment = seg_q;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl (4 digits, 8-cycle slots, 2-frame blink).
// Ports: none; drives the interface master side and checks digit/segment/pending.
module tb_seg_display_ctrl;
    localparam int ND = 4;
    localparam int SI = 8;
    localparam int BB = 2;
    localparam int BF = 2;
    localparam int FL = ND * SI;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_display_ctrl_if #(.NUM_DIGITS(ND), .BRIGHT_BITS(BB)) bus ();

    seg_display_ctrl #(
        .NUM_DIGITS(ND), .SCAN_INTERVAL(SI),
        .BRIGHT_BITS(BB), .BLINK_FRAMES(BF)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus_if(bus)
    );

    int pos;
    int checks;
    int passed;
    logic [11:0] sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic advance_to(input int m);
        while ((pos % FL) != m) tick();
    endtask

    task automatic push_frame(input logic [3:0][7:0] segs,
                              input logic [3:0] vis, input int on);
        for (int i = 0; i < ND; i++)
            for (int c = 0; c < SI; c++)
                if (vis[i] && c < on) sb.push_back({4'(1 << i), segs[i]});
                else sb.push_back(12'h000);
    endtask

    task automatic do_load(input logic [15:0] n, input logic [3:0] d);
        bus.number = n;
        bus.dp     = d;
        bus.load   = 1'b1;
        tick();
        bus.load   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.digit !== 4'h0 || bus.segment !== 8'h00 || bus.pending !== 1'b0)
            $display("FAIL reset_state got d=%h s=%h p=%b exp 0/00/0",
                     bus.digit, bus.segment, bus.pending);
        else passed++;
        rst = 1'b0;
        pos = -1;
        tick();
        checks++;
        if ({bus.digit, bus.segment} !== 12'h13F)
            $display("FAIL first_lit got %h exp 13f", {bus.digit, bus.segment});
        else passed++;
    endtask

    task automatic test_basic();
        logic [11:0] exp;
        advance_to(FL - 1);
        do_load(16'h1A3F, 4'b0000);
        checks++;
        if (bus.pending !== 1'b1) $display("FAIL basic_pend_set got %b exp 1", bus.pending);
        else passed++;
        advance_to(FL - 2);
        checks++;
        if (bus.pending !== 1'b1) $display("FAIL basic_pend_hold got %b exp 1", bus.pending);
        else passed++;
        tick();
        checks++;
        if (bus.pending !== 1'b0) $display("FAIL basic_pend_clr got %b exp 0", bus.pending);
        else passed++;
        push_frame({8'h06, 8'h77, 8'h4F, 8'h71}, 4'b1111, 8);
        push_frame({8'h06, 8'h77, 8'h4F, 8'h71}, 4'b1111, 8);
        while (sb.size() != 0) begin
            tick();
            exp = sb.pop_front();
            checks++;
            if ({bus.digit, bus.segment} !== exp)
                $display("FAIL basic_scan pos=%0d got %h exp %h",
                         pos, {bus.digit, bus.segment}, exp);
            else passed++;
        end
    endtask

    task automatic test_last_wins();
        logic [11:0] exp;
        repeat (3) tick();
        do_load(16'h1234, 4'b0000);
        tick();
        do_load(16'h5678, 4'b0000);
        checks++;
        if (bus.pending !== 1'b1) $display("FAIL lastwins_pend got %b exp 1", bus.pending);
        else passed++;
        advance_to(FL - 1);
        push_frame({8'h6D, 8'h7D, 8'h07, 8'h7F}, 4'b1111, 8);
        while (sb.size() != 0) begin
            tick();
            exp = sb.pop_front();
            checks++;
            if ({bus.digit, bus.segment} !== exp)
                $display("FAIL last_wins pos=%0d got %h exp %h",
                         pos, {bus.digit, bus.segment}, exp);
            else passed++;
        end
    endtask

    task automatic test_lz();
        logic [11:0] exp;
        bus.lz_en = 1'b1;
        do_load(16'h0040, 4'b0000);
        advance_to(FL - 1);
        push_frame({8'h00, 8'h00, 8'h66, 8'h3F}, 4'b0011, 8);
        do_load(16'h0000, 4'b0000);
        while (sb.size() != 0) begin
            exp = sb.pop_front();
            checks++;
            if ({bus.digit, bus.segment} !== exp)
                $display("FAIL lz_0040 pos=%0d got %h exp %h",
                         pos, {bus.digit, bus.segment}, exp);
            else passed++;
            if (sb.size() != 0) tick();
        end
        advance_to(FL - 1);
        push_frame({8'h00, 8'h00, 8'h00, 8'h3F}, 4'b0001, 8);
        while (sb.size() != 0) begin
            tick();
            exp = sb.pop_front();
            checks++;
            if ({bus.digit, bus.segment} !== exp)
                $display("FAIL lz_zero pos=%0d got %h exp %h",
                         pos, {bus.digit, bus.segment}, exp);
            else passed++;
        end
        tick();
        do_load(16'h0000, 4'b1000);
        advance_to(FL - 1);
        push_frame({8'hBF, 8'h3F, 8'h3F, 8'h3F}, 4'b1111, 8);
        while (sb.size() != 0) begin
            tick();
            exp = sb.pop_front();
            checks++;
            if ({bus.digit, bus.segment} !== exp)
                $display("FAIL lz_dp pos=%0d got %h exp %h",
                         pos, {bus.digit, bus.segment}, exp);
            else passed++;
        end
        bus.lz_en = 1'b0;
    endtask

    task automatic test_brightness();
        logic [11:0] exp;
        bus.brightness = 2'd1;
        do_load(16'h89AB, 4'b0000);
        advance_to(FL - 1);
        push_frame({8'h7F, 8'h6F, 8'h77, 8'h7C}, 4'b1111, 4);
        while (sb.size() != 0) begin
            tick();
            exp = sb.pop_front();
            checks++;
            if ({bus.digit, bus.segment} !== exp)
                $display("FAIL bright1 pos=%0d got %h exp %h",
                         pos, {bus.digit, bus.segment}, exp);
            else passed++;
        end
        bus.brightness = 2'd0;
        push_frame({8'h7F, 8'h6F, 8'h77, 8'h7C}, 4'b1111, 2);
        while (sb.size() != 0) begin
            tick();
            exp = sb.pop_front();
            checks++;
            if ({bus.digit, bus.segment} !== exp)
                $display("FAIL bright0 pos=%0d got %h exp %h",
                         pos, {bus.digit, bus.segment}, exp);
            else passed++;
        end
        bus.brightness = 2'd3;
    endtask

    task automatic test_blink();
        logic [11:0] exp;
        int f;
        bus.blink_mask = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            f = (pos + 1) / FL;
            push_frame({8'h7F, 8'h6F, 8'h77, 8'h7C},
                       (((f / BF) % 2) == 0) ? 4'b1111 : 4'b1110, 8);
            while (sb.size() != 0) begin
                tick();
                exp = sb.pop_front();
                checks++;
                if ({bus.digit, bus.segment} !== exp)
                    $display("FAIL blink frame=%0d pos=%0d got %h exp %h",
                             f, pos, {bus.digit, bus.segment}, exp);
                else passed++;
            end
        end
        bus.blink_mask = 4'b0000;
    endtask

    task automatic test_boundary_load();
        logic [11:0] exp;
        advance_to(FL - 2);
        do_load(16'hC0DE, 4'b0000);
        checks++;
        if (bus.pending !== 1'b1) $display("FAIL bnd_pend_hold got %b exp 1", bus.pending);
        else passed++;
        push_frame({8'h7F, 8'h6F, 8'h77, 8'h7C}, 4'b1111, 8);
        while (sb.size() != 0) begin
            tick();
            exp = sb.pop_front();
            checks++;
            if ({bus.digit, bus.segment} !== exp)
                $display("FAIL bnd_old pos=%0d got %h exp %h",
                         pos, {bus.digit, bus.segment}, exp);
            else passed++;
        end
        checks++;
        if (bus.pending !== 1'b0) $display("FAIL bnd_pend_clr got %b exp 0", bus.pending);
        else passed++;
        push_frame({8'h39, 8'h3F, 8'h5E, 8'h79}, 4'b1111, 8);
        while (sb.size() != 0) begin
            tick();
            exp = sb.pop_front();
            checks++;
            if ({bus.digit, bus.segment} !== exp)
                $display("FAIL bnd_new pos=%0d got %h exp %h",
                         pos, {bus.digit, bus.segment}, exp);
            else passed++;
        end
    endtask

    task automatic test_reset_pending();
        logic [11:0] exp;
        repeat (5) tick();
        do_load(16'hFFFF, 4'b1111);
        checks++;
        if (bus.pending !== 1'b1) $display("FAIL rstp_pend_set got %b exp 1", bus.pending);
        else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.digit !== 4'h0 || bus.segment !== 8'h00 || bus.pending !== 1'b0)
            $display("FAIL rstp_state got d=%h s=%h p=%b exp 0/00/0",
                     bus.digit, bus.segment, bus.pending);
        else passed++;
        pos = -1;
        tick();
        checks++;
        if ({bus.digit, bus.segment} !== 12'h13F)
            $display("FAIL rstp_first got %h exp 13f", {bus.digit, bus.segment});
        else passed++;
        advance_to(FL - 1);
        checks++;
        if (bus.pending !== 1'b0) $display("FAIL rstp_pend_idle got %b exp 0", bus.pending);
        else passed++;
        push_frame({8'h3F, 8'h3F, 8'h3F, 8'h3F}, 4'b1111, 8);
        while (sb.size() != 0) begin
            tick();
            exp = sb.pop_front();
            checks++;
            if ({bus.digit, bus.segment} !== exp)
                $display("FAIL rstp_shadow pos=%0d got %h exp %h",
                         pos, {bus.digit, bus.segment}, exp);
            else passed++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout pos=%0d", pos);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        passed = 0;
        pos = 0;
        bus.number = '0;
        bus.dp = '0;
        bus.load = 1'b0;
        bus.lz_en = 1'b0;
        bus.brightness = 2'd3;
        bus.blink_mask = '0;
        test_reset();
        test_basic();
        test_last_wins();
        test_lz();
        test_brightness();
        test_blink();
        test_boundary_load();
        test_reset_pending();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
